tty_console_writer: RTL and testbench

- Character-stream front end for the text-mode display driver.
- Accepts ASCII bytes over a valid/ready handshake and interprets CR, LF, BS and FF.
- Writes 16-bit character cells into the driver's text RAM over the shared hid_* bus, scrolling by RAM copy when the cursor passes the last row.
- Keeps the driver's hardware cursor registers (xcursor, ycursor) in step after every character.

---
 rtl/tty_console_writer.sv | 245 ++++++++++++++++++++++++
 tb/tb_tty_console_writer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tty_console_writer.sv
// Character-stream front end: turns ASCII bytes into text-RAM cell writes, scrolls by row copy,
// and mirrors the cursor into the display driver's xcursor/ycursor registers.
module tty_console_writer #(
  parameter int COLS       = 128,
  parameter int ROWS       = 32,
  parameter int ROW_STRIDE = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ch_valid,
  input  logic [7:0]  ch_data,
  output logic        ch_ready,
  input  logic [7:0]  attr_i,
  output logic        busy,
  output logic [6:0]  cur_x,
  output logic [5:0]  cur_y,
  output logic        hid_en,
  output logic [7:0]  hid_we,
  output logic [18:0] hid_addr,
  output logic [63:0] hid_wrdata,
  output logic        hid_sel,
  input  logic [63:0] hid_rddata
);

  localparam logic [6:0]  X_LAST    = 7'(COLS - 1);
  localparam logic [5:0]  Y_LAST    = 6'(ROWS - 1);
  localparam logic [4:0]  W_LAST    = 5'(COLS / 4 - 1);
  localparam logic [18:0] XCUR_ADDR = 19'h04010;
  localparam logic [18:0] YCUR_ADDR = 19'h04018;

  typedef enum logic [2:0] {CLR, IDLE, PUT, SCR_RD, SCR_WR, SCR_CLR, CUR_X, CUR_Y} state_t;

  state_t      r_state;
  logic [5:0]  r_row;
  logic [4:0]  r_wd;
  logic [6:0]  r_cx;
  logic [5:0]  r_cy;
  logic [7:0]  r_attr;
  logic        r_rdy;
  logic        r_busy;
  logic        r_en;
  logic [7:0]  r_we;
  logic [18:0] r_addr;
  logic [63:0] r_wrdata;

  logic        w_acc;
  logic        w_printable;
  logic        w_ctrl;
  logic        w_wd_last;
  logic        w_row_last;
  logic        w_x_last;
  logic        w_y_last;
  logic [4:0]  w_nwd;
  logic [5:0]  w_nrow;
  logic [6:0]  w_cx_dec;
  logic [7:0]  w_cell_we;
  logic [63:0] w_blank;

  function automatic logic [18:0] f_addr(input logic [5:0] row, input logic [4:0] wd);
    logic [10:0] w;
    w = 11'(row * ROW_STRIDE) + 11'(wd);
    return {5'b0, w, 3'b000};
  endfunction

  function automatic logic [63:0] f_xdat(input logic [6:0] x);
    return {57'd0, x};
  endfunction

  assign w_acc       = ch_valid && r_rdy;
  assign w_printable = ((ch_data >= 8'h20) && (ch_data <= 8'h7E)) || ch_data[7];
  assign w_ctrl      = (ch_data == 8'h0D) || (ch_data == 8'h08) ||
                       (ch_data == 8'h0A) || (ch_data == 8'h0C);
  assign w_wd_last   = (r_wd == W_LAST);
  assign w_row_last  = (r_row == Y_LAST);
  assign w_x_last    = (r_cx == X_LAST);
  assign w_y_last    = (r_cy == Y_LAST);
  assign w_nwd       = w_wd_last ? 5'd0 : r_wd + 5'd1;
  assign w_nrow      = w_wd_last ? r_row + 6'd1 : r_row;
  assign w_cx_dec    = (r_cx == 7'd0) ? 7'd0 : r_cx - 7'd1;
  assign w_cell_we   = 8'b0000_0011 << {r_cx[1:0], 1'b0};
  assign w_blank     = {4{r_attr, 8'h20}};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= CLR;
      r_row    <= '0;
      r_wd     <= '0;
      r_cx     <= '0;
      r_cy     <= '0;
      r_attr   <= 8'h0F;
      r_rdy    <= 1'b0;
      r_busy   <= 1'b1;
      r_en     <= 1'b0;
      r_we     <= '0;
      r_addr   <= '0;
      r_wrdata <= '0;
    end else begin
      case (r_state)
        CLR: begin
          // hid_en still low means we just left reset and no clear write is on the bus yet
          if (!r_en) begin
            r_row    <= '0;
            r_wd     <= '0;
            r_en     <= 1'b1;
            r_we     <= 8'hFF;
            r_addr   <= f_addr(6'd0, 5'd0);
            r_wrdata <= w_blank;
          end else if (w_wd_last && w_row_last) begin
            r_cx     <= '0;
            r_cy     <= '0;
            r_state  <= CUR_X;
            r_addr   <= XCUR_ADDR;
            r_wrdata <= '0;
          end else begin
            r_row  <= w_nrow;
            r_wd   <= w_nwd;
            r_addr <= f_addr(w_nrow, w_nwd);
          end
        end
        IDLE: begin
          if (w_acc) r_attr <= attr_i;
          if (w_acc && (w_printable || w_ctrl)) begin
            r_rdy    <= 1'b0;
            r_busy   <= 1'b1;
            r_en     <= 1'b1;
            r_we     <= 8'hFF;
            r_state  <= CUR_X;
            r_addr   <= XCUR_ADDR;
            r_wrdata <= f_xdat(r_cx);
            if (w_printable) begin
              r_state  <= PUT;
              r_we     <= w_cell_we;
              r_addr   <= f_addr(r_cy, r_cx[6:2]);
              r_wrdata <= {4{attr_i, ch_data}};
            end else begin
              case (ch_data)
                8'h0D: begin
                  r_cx     <= '0;
                  r_wrdata <= '0;
                end
                8'h08: begin
                  r_cx     <= w_cx_dec;
                  r_wrdata <= f_xdat(w_cx_dec);
                end
                8'h0A: begin
                  if (!w_y_last) begin
                    r_cy <= r_cy + 6'd1;
                  end else begin
                    r_state <= SCR_RD;
                    r_row   <= 6'd1;
                    r_wd    <= '0;
                    r_we    <= '0;
                    r_addr  <= f_addr(6'd1, 5'd0);
                  end
                end
                default: begin
                  r_state  <= CLR;
                  r_row    <= '0;
                  r_wd     <= '0;
                  r_addr   <= f_addr(6'd0, 5'd0);
                  r_wrdata <= {4{attr_i, 8'h20}};
                end
              endcase
            end
          end
        end
        PUT: begin
          r_state <= CUR_X;
          r_we    <= 8'hFF;
          r_addr  <= XCUR_ADDR;
          if (!w_x_last) begin
            r_cx     <= r_cx + 7'd1;
            r_wrdata <= f_xdat(r_cx + 7'd1);
          end else begin
            r_cx     <= '0;
            r_wrdata <= '0;
            if (!w_y_last) begin
              r_cy <= r_cy + 6'd1;
            end else begin
              r_state <= SCR_RD;
              r_row   <= 6'd1;
              r_wd    <= '0;
              r_we    <= '0;
              r_addr  <= f_addr(6'd1, 5'd0);
            end
          end
        end
        SCR_RD: begin
          r_state <= SCR_WR;
          r_we    <= 8'hFF;
          r_addr  <= f_addr(r_row - 6'd1, r_wd);
        end
        SCR_WR: begin
          r_wrdata <= hid_rddata;
          if (w_wd_last && w_row_last) begin
            r_state  <= SCR_CLR;
            r_wd     <= '0;
            r_addr   <= f_addr(Y_LAST, 5'd0);
            r_wrdata <= w_blank;
          end else begin
            r_state <= SCR_RD;
            r_row   <= w_nrow;
            r_wd    <= w_nwd;
            r_we    <= '0;
            r_addr  <= f_addr(w_nrow, w_nwd);
          end
        end
        SCR_CLR: begin
          if (w_wd_last) begin
            r_state  <= CUR_X;
            r_addr   <= XCUR_ADDR;
            r_wrdata <= f_xdat(r_cx);
          end else begin
            r_wd   <= w_nwd;
            r_addr <= f_addr(Y_LAST, w_nwd);
          end
        end
        CUR_X: begin
          r_state  <= CUR_Y;
          r_addr   <= YCUR_ADDR;
          r_wrdata <= {58'd0, r_cy};
        end
        CUR_Y: begin
          r_state <= IDLE;
          r_en    <= 1'b0;
          r_we    <= '0;
          r_rdy   <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Read data only arrives the cycle after SCR_RD, so the copy write forwards it straight through.
  assign hid_wrdata = (r_state == SCR_WR) ? hid_rddata : r_wrdata;
  assign hid_en     = r_en;
  assign hid_sel    = r_en;
  assign hid_we     = r_we;
  assign hid_addr   = r_addr;
  assign ch_ready   = r_rdy;
  assign busy       = r_busy;
  assign cur_x      = r_cx;
  assign cur_y      = r_cy;

endmodule

// File: tb/tb_tty_console_writer.sv
// Bench for tty_console_writer: a RAM model answers bus reads; expected accesses go through a queue.
module tb_tty_console_writer;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        ch_valid = 1'b0;
  logic [7:0]  ch_data = 8'h00;
  logic [7:0]  attr_i = 8'h00;
  logic        ch_ready;
  logic        busy;
  logic [6:0]  cur_x;
  logic [5:0]  cur_y;
  logic        hid_en;
  logic [7:0]  hid_we;
  logic [18:0] hid_addr;
  logic [63:0] hid_wrdata;
  logic        hid_sel;
  logic [63:0] hid_rddata = '0;

  tty_console_writer dut (
    .clk_i(clk_i), .rst_i(rst_i), .ch_valid(ch_valid), .ch_data(ch_data),
    .ch_ready(ch_ready), .attr_i(attr_i), .busy(busy), .cur_x(cur_x), .cur_y(cur_y),
    .hid_en(hid_en), .hid_we(hid_we), .hid_addr(hid_addr), .hid_wrdata(hid_wrdata),
    .hid_sel(hid_sel), .hid_rddata(hid_rddata)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic        wr;
    logic [7:0]  we;
    logic [18:0] addr;
    logic [63:0] data;
  } acc_t;

  acc_t        exp_q[$];
  acc_t        mon_e;
  logic [63:0] ram    [0:4095];
  logic [63:0] shadow [0:4095];
  logic        do_fill = 1'b0;
  logic [18:0] last_addr = '0;
  int          n_chk = 0;
  int          n_fail = 0;
  int          mx, my, lat;
  logic [7:0]  m_attr;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d,
                                        input logic [7:0] we);
    logic [63:0] r;
    r = old;
    for (int b = 0; b < 8; b++) if (we[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [63:0] pat(input int i);
    return {32'(i) * 32'h9E3779B1, (32'(i) * 32'h85EBCA77) ^ 32'hDEADBEEF};
  endfunction

  function automatic logic [18:0] waddr(input int row, input int wd);
    return 19'((row * 32 + wd) * 8);
  endfunction

  function automatic logic [7:0] pc(input int i);
    return (i < 95) ? 8'(32 + i) : 8'(128 + i);
  endfunction

  // Text RAM as the driver presents it: one-cycle read latency, byte-masked writes.
  always @(posedge clk_i) begin
    if (do_fill) begin
      for (int i = 0; i < 4096; i++) ram[i] <= pat(i);
    end else if (hid_en) begin
      if (hid_we == 8'h00) hid_rddata <= ram[hid_addr[14:3]];
      else ram[hid_addr[14:3]] <= merge(ram[hid_addr[14:3]], hid_wrdata, hid_we);
    end
  end

  always @(negedge clk_i) begin
    if (rst_i) begin
      last_addr = '0;
    end else if (hid_en) begin
      check("hid_sel", hid_sel, 1);
      if (exp_q.size() == 0) begin
        check("spurious_en", hid_en, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("addr", hid_addr, mon_e.addr);
        check("we", hid_we, mon_e.we);
        if (mon_e.wr) check("wrdata", hid_wrdata, mon_e.data);
        last_addr = mon_e.addr;
      end
    end else begin
      check("hold_addr", hid_addr, last_addr);
      check("sel_idle", hid_sel, 0);
    end
  end

  task automatic push(input logic wr, input logic [7:0] we, input logic [18:0] addr,
                      input logic [63:0] data);
    exp_q.push_back('{wr, we, addr, data});
    if (wr) shadow[addr[14:3]] = merge(shadow[addr[14:3]], data, we);
  endtask

  task automatic push_cursor();
    push(1'b1, 8'hFF, 19'h04010, 64'(mx));
    push(1'b1, 8'hFF, 19'h04018, 64'(my));
  endtask

  task automatic push_clear(input logic [7:0] a);
    for (int r = 0; r < 32; r++)
      for (int w = 0; w < 32; w++) push(1'b1, 8'hFF, waddr(r, w), {4{a, 8'h20}});
    mx = 0;
    my = 0;
  endtask

  task automatic push_scroll();
    for (int s = 1; s < 32; s++)
      for (int w = 0; w < 32; w++) begin
        push(1'b0, 8'h00, waddr(s, w), 64'd0);
        push(1'b1, 8'hFF, waddr(s - 1, w), shadow[s * 32 + w]);
      end
    for (int w = 0; w < 32; w++) push(1'b1, 8'hFF, waddr(31, w), {4{m_attr, 8'h20}});
  endtask

  task automatic newline();
    if (my < 31) my++;
    else push_scroll();
  endtask

  task automatic model(input logic [7:0] c, input logic [7:0] a);
    m_attr = a;
    if ((c >= 8'h20 && c <= 8'h7E) || c >= 8'h80) begin
      push(1'b1, 8'h03 << (2 * (mx % 4)), waddr(my, mx / 4), {4{a, c}});
      if (mx < 127) mx++;
      else begin
        mx = 0;
        newline();
      end
      push_cursor();
    end else begin
      case (c)
        8'h0D: begin mx = 0; push_cursor(); end
        8'h08: begin if (mx > 0) mx--; push_cursor(); end
        8'h0A: begin newline(); push_cursor(); end
        8'h0C: begin push_clear(a); push_cursor(); end
        default: ;
      endcase
    end
  endtask

  task automatic wait_ready(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk_i);
      if (ch_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check(tag, ch_ready, 1);
  endtask

  task automatic send(input logic [7:0] c, input logic [7:0] a, input bit wait_done,
                      output int l);
    bit ok;
    model(c, a);
    wait_ready("rdy_before");
    ch_valid = 1'b1;
    ch_data  = c;
    attr_i   = a;
    @(posedge clk_i);
    #1 ch_valid = 1'b0;
    l = 1;
    if (wait_done) begin
      ok = 1'b0;
      for (int i = 0; i < 5000; i++) begin
        @(negedge clk_i);
        if (ch_ready) begin
          ok = 1'b1;
          break;
        end
        l++;
      end
      if (!ok) check("rdy_after", ch_ready, 1);
      check("drain", exp_q.size(), 0);
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) shadow[i] = '0;
    mx = 0;
    my = 0;
    m_attr = 8'h0F;
    #1 rst_i = 1'b1;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_ready", ch_ready, 0);
    check("rst_busy", busy, 1);
    check("rst_cur_x", cur_x, 0);
    check("rst_cur_y", cur_y, 0);
    check("rst_en", hid_en, 0);
    check("rst_we", hid_we, 0);
    check("rst_addr", hid_addr, 0);
    check("rst_wrdata", hid_wrdata, 0);

    push_clear(8'h0F);
    push_cursor();
    rst_i = 1'b0;
    wait_ready("clr_timeout");
    check("clr_drain", exp_q.size(), 0);
    check("idle_busy", busy, 0);

    for (int i = 0; i < 5; i++) send(8'h20, 8'h07, 1'b1, lat);
    send(8'h41, 8'h1F, 1'b1, lat);
    check("lat_put", lat, 4);
    check("A_cur_x", cur_x, 6);
    check("A_cur_y", cur_y, 0);

    send(8'h0D, 8'h07, 1'b1, lat);
    for (int i = 0; i < 128; i++) send(pc(i), 8'(i), 1'b1, lat);
    check("row0_cur_x", cur_x, 0);
    check("row0_cur_y", cur_y, 1);

    send(8'h08, 8'h07, 1'b1, lat);
    check("bs0_cur_x", cur_x, 0);
    for (int i = 0; i < 40; i++) send(8'h78, 8'h1E, 1'b1, lat);
    check("x40", cur_x, 40);
    send(8'h08, 8'h07, 1'b1, lat);
    check("bs_cur_x", cur_x, 39);
    send(8'h0D, 8'h07, 1'b1, lat);
    check("cr_cur_x", cur_x, 0);

    send(8'h07, 8'h07, 1'b1, lat);
    check("bel_lat", lat, 1);
    check("bel_busy", busy, 0);
    send(8'h1B, 8'h07, 1'b1, lat);
    check("esc_lat", lat, 1);
    repeat (5) @(negedge clk_i);
    check("bel_ready", ch_ready, 1);

    for (int i = 0; i < 30; i++) send(8'h0A, 8'h07, 1'b1, lat);
    check("lf_cur_y", cur_y, 31);

    @(negedge clk_i);
    do_fill = 1'b1;
    for (int i = 0; i < 4096; i++) shadow[i] = pat(i);
    @(negedge clk_i);
    do_fill = 1'b0;
    send(8'h0A, 8'h3C, 1'b1, lat);
    check("scroll_lat", lat, 2019);
    check("scroll_cur_y", cur_y, 31);
    check("scroll_cur_x", cur_x, 0);

    for (int i = 0; i < 128; i++) send(pc(127 - i), 8'h4B, 1'b1, lat);
    check("wrap_cur_y", cur_y, 31);
    check("wrap_cur_x", cur_x, 0);

    send(8'h0C, 8'h2A, 1'b1, lat);
    check("ff_lat", lat, 1027);
    check("ff_cur_x", cur_x, 0);
    check("ff_cur_y", cur_y, 0);

    for (int i = 0; i < 31; i++) send(8'h0A, 8'h07, 1'b1, lat);
    send(8'h0A, 8'h55, 1'b0, lat);
    repeat (100) @(posedge clk_i);
    #2 rst_i = 1'b1;
    exp_q.delete();
    #1;
    check("mid_en", hid_en, 0);
    check("mid_we", hid_we, 0);
    check("mid_addr", hid_addr, 0);
    check("mid_wrdata", hid_wrdata, 0);
    check("mid_ready", ch_ready, 0);
    check("mid_busy", busy, 1);
    m_attr = 8'h0F;
    push_clear(8'h0F);
    push_cursor();
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    wait_ready("reclr_timeout");
    check("reclr_drain", exp_q.size(), 0);
    check("reclr_cur_x", cur_x, 0);
    check("reclr_cur_y", cur_y, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
